// File: rtl/layer1_seq.sv
// Layer-pass sequencer: walks N_GRP output groups of N_TAPS weight/pixel taps
// through a 10-lane MAC array and hands each group's column sums to a consumer.
//
// state  | meaning
// -------+----------------------------------------------------------
// IDLE   | waiting for start, accumulator held clear
// CLEAR  | clear accumulators, issue tap-0 addresses for group g
// ACCUM  | N_TAPS cycles feeding operands, prefetching the next tap
// DRAIN  | MAC_LAT cycles for the array pipeline, capture on the last
// OUTPUT | group presented on out_data until out_ready
// DONE   | one-cycle end-of-pass pulse
module layer1_seq #(
  parameter int N_TAPS  = 25,
  parameter int N_GRP   = 16,
  parameter int AW      = 12,
  parameter int MAC_LAT = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic          busy,
  output logic [AW-1:0] w_addr,
  input  logic [15:0]   w_data,
  output logic [AW-1:0] p_addr,
  input  logic [159:0]  p_data,
  output logic [15:0]   mac_weight,
  output logic [159:0]  mac_pixels,
  output logic          mac_clr,
  input  logic [159:0]  mac_sum,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [159:0]  out_data,
  output logic [7:0]    out_grp,
  output logic          done
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CLEAR  = 3'd1;
  localparam logic [2:0] S_ACCUM  = 3'd2;
  localparam logic [2:0] S_DRAIN  = 3'd3;
  localparam logic [2:0] S_OUTPUT = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  localparam logic [7:0]    K_LAST     = 8'(N_TAPS - 1);
  localparam logic [7:0]    G_LAST     = 8'(N_GRP - 1);
  localparam logic [8:0]    N_TAPS_9   = 9'(N_TAPS);
  localparam logic [AW-1:0] TAPS_AW    = AW'(N_TAPS);
  localparam logic [2:0]    DRAIN_LOAD = 3'(MAC_LAT - 1);

  logic [2:0]    state;
  logic [7:0]    g;
  logic [7:0]    k;
  logic [2:0]    drain_cnt;
  logic [AW-1:0] w_base;

  // Addresses are registered one cycle ahead so the synchronous memories
  // deliver tap k's data exactly in ACCUM cycle k.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      g         <= 8'd0;
      k         <= 8'd0;
      drain_cnt <= 3'd0;
      w_base    <= '0;
      w_addr    <= '0;
      p_addr    <= '0;
      out_data  <= '0;
      out_grp   <= 8'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state  <= S_CLEAR;
            g      <= 8'd0;
            k      <= 8'd0;
            w_base <= '0;
            w_addr <= '0;
            p_addr <= '0;
          end
        end
        S_CLEAR: begin
          state <= S_ACCUM;
          k     <= 8'd0;
          if (N_TAPS > 1) begin
            w_addr <= w_base + AW'(1);
            p_addr <= AW'(1);
          end
        end
        S_ACCUM: begin
          if (k == K_LAST) begin
            state     <= S_DRAIN;
            drain_cnt <= DRAIN_LOAD;
          end else begin
            k <= k + 8'd1;
            if (({1'b0, k} + 9'd2) < N_TAPS_9) begin
              w_addr <= w_base + AW'(k) + AW'(2);
              p_addr <= AW'(k) + AW'(2);
            end
          end
        end
        S_DRAIN: begin
          if (drain_cnt == 3'd0) begin
            out_data <= mac_sum;
            out_grp  <= g;
            state    <= S_OUTPUT;
          end else begin
            drain_cnt <= drain_cnt - 3'd1;
          end
        end
        S_OUTPUT: begin
          if (out_ready) begin
            if (g == G_LAST) begin
              state <= S_DONE;
            end else begin
              g      <= g + 8'd1;
              w_base <= w_base + TAPS_AW;
              w_addr <= w_base + TAPS_AW;
              p_addr <= '0;
              state  <= S_CLEAR;
            end
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy       = (state != S_IDLE);
  assign out_valid  = (state == S_OUTPUT);
  assign done       = (state == S_DONE);
  assign mac_clr    = (state == S_IDLE) || (state == S_CLEAR) || (state == S_DONE);
  assign mac_weight = (state == S_ACCUM) ? w_data : 16'd0;
  assign mac_pixels = (state == S_ACCUM) ? p_data : 160'd0;

endmodule

// File: tb/tb_layer1_seq.sv
// Randomized scoreboard bench for layer1_seq: a 4x3 configuration with a
// 2-cycle MAC array, plus a 1x1 instance for the single-tap corner case.
module tb_layer1_seq;
  localparam int NT = 4, NG = 3, ML = 2, AW = 12;
  localparam int AWB = 4;

  typedef struct { logic [7:0] grp; logic [159:0] data; bit last; } grp_t;
  typedef struct { logic [15:0] w; logic [159:0] p; } op_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, start_main, start_spam, start_a;
  logic busy_a, mac_clr_a, out_valid_a, ready_a, done_a;
  logic [AW-1:0] w_addr_a, p_addr_a;
  logic [15:0] w_data_a, mac_weight_a;
  logic [159:0] p_data_a, mac_pixels_a, mac_sum_a, out_data_a;
  logic [7:0] out_grp_a;

  logic start_b, busy_b, mac_clr_b, out_valid_b, done_b;
  logic ready_b = 1'b1;
  logic [AWB-1:0] w_addr_b, p_addr_b;
  logic [15:0] w_data_b, mac_weight_b;
  logic [159:0] p_data_b, mac_pixels_b, mac_sum_b, out_data_b;
  logic [7:0] out_grp_b;

  assign start_a = start_main | start_spam;

  layer1_seq #(.N_TAPS(NT), .N_GRP(NG), .AW(AW), .MAC_LAT(ML)) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .busy(busy_a),
    .w_addr(w_addr_a), .w_data(w_data_a), .p_addr(p_addr_a), .p_data(p_data_a),
    .mac_weight(mac_weight_a), .mac_pixels(mac_pixels_a), .mac_clr(mac_clr_a),
    .mac_sum(mac_sum_a), .out_valid(out_valid_a), .out_ready(ready_a),
    .out_data(out_data_a), .out_grp(out_grp_a), .done(done_a));

  layer1_seq #(.N_TAPS(1), .N_GRP(1), .AW(AWB), .MAC_LAT(1)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .busy(busy_b),
    .w_addr(w_addr_b), .w_data(w_data_b), .p_addr(p_addr_b), .p_data(p_data_b),
    .mac_weight(mac_weight_b), .mac_pixels(mac_pixels_b), .mac_clr(mac_clr_b),
    .mac_sum(mac_sum_b), .out_valid(out_valid_b), .out_ready(ready_b),
    .out_data(out_data_b), .out_grp(out_grp_b), .done(done_b));

  int passed = 0, total = 0;

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Memories and MAC arrays of the environment
  logic [15:0]  wmem [16];
  logic [159:0] pmem [NT];
  logic [15:0]  dw_a;
  logic [159:0] dp_a, acc_a, acc_b;

  function automatic logic [159:0] mac_step(input logic [159:0] acc, input logic [15:0] w,
                                            input logic [159:0] p);
    logic [159:0] r;
    logic [31:0] pr;
    for (int i = 0; i < 10; i++) begin
      pr = w * p[i*16 +: 16];
      r[i*16 +: 16] = acc[i*16 +: 16] + pr[15:0];
    end
    return r;
  endfunction

  always @(posedge clk) begin
    w_data_a <= (w_addr_a < 16) ? wmem[w_addr_a[3:0]] : 16'd0;
    p_data_a <= (p_addr_a < NT) ? pmem[p_addr_a[1:0]] : 160'd0;
    w_data_b <= (w_addr_b == 0) ? 16'd2 : 16'd0;
    p_data_b <= (p_addr_b == 0) ? {10{16'd7}} : 160'd0;
    dw_a  <= mac_weight_a;
    dp_a  <= mac_pixels_a;
    acc_a <= mac_clr_a ? 160'd0 : mac_step(acc_a, dw_a, dp_a);
    acc_b <= mac_clr_b ? 160'd0 : mac_step(acc_b, mac_weight_b, mac_pixels_b);
  end
  assign mac_sum_a = acc_a;
  assign mac_sum_b = acc_b;

  // Reference model: each group's lane sum is the dot product of its weights
  // with the tap pixels, truncated to 16 bits.
  function automatic logic [159:0] ref_sum(input int g);
    logic [159:0] r;
    longint unsigned s;
    for (int i = 0; i < 10; i++) begin
      s = 0;
      for (int k = 0; k < NT; k++)
        s += longint'(wmem[g*NT+k]) * longint'(pmem[k][i*16 +: 16]);
      r[i*16 +: 16] = s[15:0];
    end
    return r;
  endfunction

  grp_t sbq[$];
  op_t  opq[$];
  grp_t sbq_b[$];

  int mode = 0;
  bit spam_en = 0;

  task automatic prepare_pass();
    logic [159:0] px;
    for (int a = 0; a < 16; a++) wmem[a] = 16'($urandom_range(1, 65535));
    for (int k = 0; k < NT; k++) begin
      for (int j = 0; j < 5; j++) px[j*32 +: 32] = $urandom;
      pmem[k] = px;
    end
    for (int g = 0; g < NG; g++) begin
      sbq.push_back('{grp: 8'(g), data: ref_sum(g), last: (g == NG-1)});
      for (int k = 0; k < NT; k++) opq.push_back('{w: wmem[g*NT+k], p: pmem[k]});
    end
  endtask

  // Consumer ready: 0 = always ready, 1 = random, 2 = stall 5 cycles per group
  int stall_drv = 0;
  initial begin
    ready_a = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (mode)
        0: ready_a = 1'b1;
        1: ready_a = 1'($urandom_range(0, 1));
        default: begin
          if (out_valid_a && stall_drv < 5) begin
            ready_a = 1'b0;
            stall_drv++;
          end else begin
            ready_a = 1'b1;
            if (!out_valid_a) stall_drv = 0;
          end
        end
      endcase
    end
  end

  initial begin
    start_spam = 1'b0;
    forever begin
      @(posedge clk); #1;
      start_spam = spam_en && reset &&
                   (done_a || (mac_weight_a != 0 && $urandom_range(0, 3) == 0));
    end
  end

  // Monitor for the main instance
  int clr_cnt = 0, grp_cyc = 0, stall_mon = 0, hs_cnt = 0, done_cnt = 0;
  bit prev_last = 0, hs_last = 0, hold_valid = 0;
  logic [159:0] hold_data;
  logic [7:0] hold_grp;
  grp_t e;
  op_t o;

  always @(negedge clk) begin
    if (!reset) begin
      clr_cnt = 0; grp_cyc = 0; stall_mon = 0; prev_last = 0; hold_valid = 0;
    end else begin
      hs_last = 0;
      if (mac_weight_a != 0 || mac_pixels_a != 0) begin
        if (opq.size() == 0) check("unexpected_operand", opq.size(), 1);
        else begin
          o = opq.pop_front();
          check("op_weight", mac_weight_a, o.w);
          check("op_pixels", mac_pixels_a, o.p);
        end
      end
      if (busy_a && mac_clr_a) begin
        clr_cnt++;
        grp_cyc = 1;
      end else if (busy_a) grp_cyc++;
      if (out_valid_a) begin
        if (hold_valid) begin
          check("hold_data", out_data_a, hold_data);
          check("hold_grp", out_grp_a, hold_grp);
        end
        if (ready_a) begin
          if (sbq.size() == 0) check("unexpected_group", sbq.size(), 1);
          else begin
            e = sbq.pop_front();
            check("grp_data", out_data_a, e.data);
            check("grp_index", out_grp_a, e.grp);
            hs_last = e.last;
          end
          check("clr_once_per_group", clr_cnt, 1);
          if (mode == 0) check("group_latency", grp_cyc, 2 + NT + ML);
          if (mode == 2) check("stall_cycles", stall_mon, 5);
          clr_cnt = 0; stall_mon = 0; hold_valid = 0;
          hs_cnt++;
        end else begin
          hold_valid = 1;
          hold_data  = out_data_a;
          hold_grp   = out_grp_a;
          stall_mon++;
        end
      end
      if (done_a) begin
        check("done_after_last_hs", prev_last, 1);
        done_cnt++;
        clr_cnt = 0;
      end
      prev_last = hs_last;
    end
  end

  // Monitor for the single-tap instance
  int ops_b = 0, done_b_cnt = 0;
  grp_t eb;
  always @(negedge clk) begin
    if (reset) begin
      if (busy_b) check("b_w_addr", w_addr_b, 0);
      if (mac_weight_b != 0) begin
        check("b_op_weight", mac_weight_b, 2);
        ops_b++;
      end
      if (out_valid_b) begin
        if (sbq_b.size() == 0) check("b_unexpected_group", sbq_b.size(), 1);
        else begin
          eb = sbq_b.pop_front();
          check("b_grp_data", out_data_b, eb.data);
          check("b_grp_index", out_grp_b, eb.grp);
        end
      end
      if (done_b) done_b_cnt++;
    end
  end

  task automatic check_reset_vals(input string tag);
    check({tag, "_busy"}, busy_a, 0);
    check({tag, "_out_valid"}, out_valid_a, 0);
    check({tag, "_done"}, done_a, 0);
    check({tag, "_mac_clr"}, mac_clr_a, 1);
    check({tag, "_out_data"}, out_data_a, 0);
    check({tag, "_out_grp"}, out_grp_a, 0);
    check({tag, "_w_addr"}, w_addr_a, 0);
    check({tag, "_p_addr"}, p_addr_a, 0);
    check({tag, "_mac_weight"}, mac_weight_a, 0);
    check({tag, "_mac_pixels"}, mac_pixels_a, 0);
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start_main = 1'b1;
    @(posedge clk); #1 start_main = 1'b0;
  endtask

  task automatic run_pass_a(input int m, input bit spam);
    int d0, h0, cyc;
    mode = m;
    prepare_pass();
    d0 = done_cnt;
    h0 = hs_cnt;
    spam_en = spam;
    pulse_start();
    cyc = 0;
    while (done_cnt == d0 && cyc < 3000) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("pass_done_seen", done_cnt != d0, 1);
    repeat (4) @(posedge clk);
    #1;
    spam_en = 0;
    check("busy_after_done", busy_a, 0);
    check("done_pulses", done_cnt - d0, 1);
    check("handshakes", hs_cnt - h0, NG);
    check("sb_empty", sbq.size(), 0);
    check("ops_empty", opq.size(), 0);
  endtask

  task automatic reset_mid_pass();
    int cyc, h0, d0;
    mode = 0;
    prepare_pass();
    h0 = hs_cnt;
    pulse_start();
    cyc = 0;
    while (!(hs_cnt - h0 == 1 && mac_weight_a != 0) && cyc < 500) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("reached_grp1_accum", (hs_cnt - h0 == 1) && (mac_weight_a != 0), 1);
    reset = 1'b0;
    #1;
    check_reset_vals("midpass_rst");
    sbq.delete();
    opq.delete();
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    d0 = done_cnt;
    h0 = hs_cnt;
    repeat (12) @(posedge clk);
    #1;
    check("no_done_after_rst", done_cnt - d0, 0);
    check("no_group_after_rst", hs_cnt - h0, 0);
    check("idle_after_rst", busy_a, 0);
  endtask

  task automatic run_b();
    int o0, d0, cyc;
    o0 = ops_b;
    d0 = done_b_cnt;
    sbq_b.push_back('{grp: 8'd0, data: {10{16'd14}}, last: 1'b1});
    @(posedge clk); #1 start_b = 1'b1;
    cyc = 0;
    do begin
      @(posedge clk); #1;
      start_b = 1'b0;
      cyc++;
    end while (!done_b && cyc < 50);
    check("b_start_to_done", cyc, 5);
    repeat (2) @(posedge clk);
    #1;
    check("b_ops", ops_b - o0, 1);
    check("b_done_pulses", done_b_cnt - d0, 1);
    check("b_sb_empty", sbq_b.size(), 0);
    check("b_idle", busy_b, 0);
  endtask

  initial begin
    reset = 1'b0;
    start_main = 1'b0;
    start_b = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("por");
    reset = 1'b1;
    run_pass_a(0, 0);
    run_pass_a(2, 0);
    run_pass_a(1, 1);
    run_pass_a(0, 1);
    run_b();
    reset_mid_pass();
    run_pass_a(0, 0);
    for (int i = 0; i < 4; i++) run_pass_a($urandom_range(0, 2), 1'($urandom_range(0, 1)));
    run_b();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
